// File: rtl/selector_debounce_updown.sv
// selector_debounce_updown: debounced up/down buttons step a selection index over [SEL_MIN..SEL_MAX]
// with wrap/saturate, press/release edge select and optional auto-repeat while one button is held.
module selector_debounce_updown #(
   parameter int DB_N    = 11,
   parameter int SEL_W   = 2,
   parameter int SEL_MIN = 1,
   parameter int SEL_MAX = 2,
   parameter int SEL_RST = 1,
   parameter int WRAP    = 1,
   parameter int EDGE    = 0,
   parameter int RPT_N   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_dn,
   output logic [SEL_W-1:0] sel,
   output logic             sel_changed,
   output logic             at_min,
   output logic             at_max,
   output logic             db_up,
   output logic             db_dn
);
   localparam int RW = RPT_N > 0 ? RPT_N : 1;
   localparam logic [SEL_W:0]   MIN_V = (SEL_W+1)'(SEL_MIN);
   localparam logic [SEL_W:0]   MAX_V = (SEL_W+1)'(SEL_MAX);
   localparam logic [SEL_W-1:0] RST_V = SEL_W'(SEL_RST);

   if (SEL_MIN > SEL_MAX || SEL_RST < SEL_MIN || SEL_RST > SEL_MAX || SEL_MAX >= 2**SEL_W) begin : g_bad
      $error("selector_debounce_updown: illegal SEL_MIN/SEL_MAX/SEL_RST");
   end

   // channel 0 = up, channel 1 = dn
   logic [1:0]        btn, s1_q, s2_q, db_q, db_d, dbr_q, ev, stp;
   logic [DB_N-1:0]   cnt_q [2];
   logic [DB_N-1:0]   cnt_d [2];
   logic [RW-1:0]     rpt_q, rpt_d;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W:0]    sel_w, up_nx, dn_nx, sel_d;
   logic              chg_q, chg_d, run, rpt_hit;

   assign btn = {btn_dn, btn_up};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = (s1_q[i] != s2_q[i]) ? '0 : cnt_q[i][DB_N-1] ? cnt_q[i] : cnt_q[i] + 1'b1;
         db_d[i]  = cnt_q[i][DB_N-1] ? s2_q[i] : db_q[i];
      end
      ev      = EDGE != 0 ? (db_q & ~dbr_q) : (~db_q & dbr_q);
      run     = (RPT_N > 0) && (db_q[0] ^ db_q[1]);
      rpt_d   = run ? rpt_q + 1'b1 : '0;
      rpt_hit = run && (&rpt_q);
      stp     = ev | ({2{rpt_hit}} & db_q);
      sel_w   = {1'b0, sel_q};
      up_nx   = (sel_w == MAX_V) ? (WRAP != 0 ? MIN_V : sel_w) : sel_w + 1'b1;
      dn_nx   = (sel_w == MIN_V) ? (WRAP != 0 ? MAX_V : sel_w) : sel_w - 1'b1;
      sel_d   = (stp == 2'b01) ? up_nx : (stp == 2'b10) ? dn_nx : sel_w;
      chg_d   = sel_d != sel_w;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q  <= '0;
         s2_q  <= '0;
         db_q  <= '0;
         dbr_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
         rpt_q <= '0;
         sel_q <= RST_V;
         chg_q <= 1'b0;
      end else begin
         s1_q  <= btn;
         s2_q  <= s1_q;
         db_q  <= db_d;
         dbr_q <= db_q;
         for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
         rpt_q <= rpt_d;
         sel_q <= sel_d[SEL_W-1:0];
         chg_q <= chg_d;
      end
   end

   assign sel         = sel_q;
   assign sel_changed = chg_q;
   assign at_min      = sel_q == MIN_V[SEL_W-1:0];
   assign at_max      = sel_q == MAX_V[SEL_W-1:0];
   assign db_up       = db_q[0];
   assign db_dn       = db_q[1];
endmodule
